// File: rtl/latch_bus_capture.sv
// latch_bus_capture
//   Captures a bus driven by an upstream transparent latch that runs
//   asynchronously to i_clk. The bus and the latch enable are first
//   synchronized. A value is accepted once it has been seen on
//   STABLE_CYCLES consecutive synchronized samples while the latch is
//   holding. Each accepted value that differs from the last stored value
//   is pushed into a small FIFO. The FIFO has no fall-through path.
//
//   State table (o_state encoding):
//     state  | meaning
//     IDLE   | upstream latch transparent (sen=1), nothing is trusted
//     SETTLE | latch holding, waiting for the candidate value to stay stable
//     HOLD   | candidate accepted, waiting for the bus to change
//
// Ports
//   i_clk       sole clock, rising edge
//   i_arst_n    asynchronous active-low reset
//   i_a         latched bus, asynchronous to i_clk
//   i_en        upstream latch enable, asynchronous (1 = transparent)
//   o_valid     FIFO head holds data
//   i_ready     consumer takes the head this cycle
//   o_data      FIFO head value (0 when empty)
//   o_count     FIFO occupancy, 0..DEPTH
//   o_overflow  sticky flag: an accepted value was dropped on a full FIFO
//   i_clr_ovf   synchronous clear of o_overflow (a same-cycle drop wins)
//   o_state     FSM state: IDLE=0, SETTLE=1, HOLD=2
module latch_bus_capture #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [WIDTH-1:0]           i_a,
  input  logic                       i_en,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  input  logic                       i_clr_ovf,
  output logic [1:0]                 o_state
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronizers: nothing else in the block looks at i_a or i_en.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]       sync_a [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_en;
  logic [WIDTH-1:0]       sa;
  logic                   sen;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_a[i] <= '0;
      end
      sync_en <= '0;
    end else begin
      sync_a[0] <= i_a;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_a[i] <= sync_a[i-1];
      end
      sync_en <= {sync_en[SYNC_STAGES-2:0], i_en};
    end
  end

  assign sa  = sync_a[SYNC_STAGES-1];
  assign sen = sync_en[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Settle FSM
  // ---------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] last;
  logic             last_vld;
  logic             accept;
  logic             push_req;

  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // State register, plus the record of the last value actually stored.
  // last only moves on a real push so a dropped value is retried the
  // next time it is accepted.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= ST_IDLE;
      cand     <= '0;
      cnt      <= '0;
      last     <= '0;
      last_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      if (do_push) begin
        last     <= cand;
        last_vld <= 1'b1;
      end
    end
  end

  // Next-state logic. A transparent latch overrides everything else.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (sen) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SETTLE;
          cand_nxt  = sa;
          cnt_nxt   = '0;
        end
        ST_SETTLE: begin
          if (sa != cand) begin
            cand_nxt = sa;
            cnt_nxt  = '0;
          end else if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end
        end
        ST_HOLD: begin
          if (sa != cand) begin
            state_nxt = ST_SETTLE;
            cand_nxt  = sa;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: repeated acceptance of the stored value is suppressed.
  always_comb begin
    push_req = accept && (!last_vld || (cand != last));
    o_state  = state;
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [NW-1:0]    count;
  logic             ovf;

  assign full    = (count == CNT_FULL);
  assign o_valid = (count != '0);
  assign do_pop  = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= cand;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // Memory is not reset, so the head is masked while the FIFO is empty.
  assign o_data     = o_valid ? mem[rd_ptr] : '0;
  assign o_count    = count;
  assign o_overflow = ovf;

endmodule

// File: doc/latch_bus_capture.md
LATCH_BUS_CAPTURE -- requirements
Module: latch_bus_capture

Interface
REQ-001 Parameter WIDTH, default 8: width of the captured latch bus.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on i_a and i_en, minimum 2.
REQ-003 Parameter STABLE_CYCLES, default 3: consecutive equal synchronized samples required to accept a value, minimum 1.
REQ-004 Parameter DEPTH, default 4: output FIFO entries, power of two.
REQ-005 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_arst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_a  in  WIDTH  latched bus from the upstream always_latch stage, asynchronous to i_clk.
REQ-008 i_en  in  1  upstream latch enable, asynchronous; 1 = latch transparent, 0 = latch holding.
REQ-009 o_valid  out  1  FIFO head holds data.
REQ-010 i_ready  in  1  consumer accepts head this cycle.
REQ-011 o_data  out  WIDTH  FIFO head value.
REQ-012 o_count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-013 o_overflow  out  1  sticky: an accepted value was dropped on a full FIFO.
REQ-014 i_clr_ovf  in  1  synchronous clear of o_overflow.
REQ-015 o_state  out  2  FSM state: IDLE=0, SETTLE=1, HOLD=2.

Function
REQ-016 i_a and i_en SHALL each pass through SYNC_STAGES flops, giving sa and sen; no other logic SHALL use i_a or i_en.
REQ-017 FSM registers: cand (WIDTH), cnt (counts to STABLE_CYCLES-1), last (WIDTH), last_vld (1).
REQ-018 In any state, sen=1 SHALL force IDLE with cnt=0; this rule takes priority over all others.
REQ-019 IDLE with sen=0: go to SETTLE, load cand=sa, set cnt=0.
REQ-020 SETTLE with sa!=cand: load cand=sa, set cnt=0, stay in SETTLE.
REQ-021 SETTLE with sa==cand and cnt<STABLE_CYCLES-1: increment cnt.
REQ-022 SETTLE with sa==cand and cnt==STABLE_CYCLES-1: accept cand and go to HOLD.
REQ-023 On accept, a push SHALL be requested only if last_vld=0 or cand!=last; an accept equal to last SHALL push nothing.
REQ-024 A successful push SHALL set last=cand and last_vld=1; a dropped push SHALL leave last and last_vld unchanged.
REQ-025 HOLD with sa!=cand: go to SETTLE, load cand=sa, set cnt=0.
REQ-026 HOLD with sa==cand: stay in HOLD; no further push.
REQ-027 Latency: a change on i_a, with i_en held 0, SHALL raise o_valid after SYNC_STAGES+STABLE_CYCLES+1 rising edges, counting the edge that first samples the new value (6 with defaults).
REQ-028 Pop occurs when o_valid=1 and i_ready=1; o_data SHALL then advance to the next entry on the following cycle.
REQ-029 o_data SHALL remain stable while o_valid=1 and i_ready=0.
REQ-030 Full FIFO with push requested and no pop: the value SHALL be dropped and o_overflow set to 1 on the next edge.
REQ-031 Full FIFO with push and pop in the same cycle: both SHALL be performed; o_count stays DEPTH; o_overflow is not set.
REQ-032 Empty FIFO with a push: o_valid SHALL be 1 the next cycle; the FIFO has no fall-through, and i_ready is ignored while o_valid=0.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL equal pushes minus pops.
REQ-034 i_clr_ovf=1 SHALL clear o_overflow; if a drop occurs in the same cycle, set wins and o_overflow=1.

Reset
REQ-035 While i_arst_n=0: all synchronizer flops=0, state=IDLE, cnt=0, cand=0, last=0, last_vld=0, FIFO pointers=0.
REQ-036 While i_arst_n=0 the outputs SHALL be o_valid=0, o_count=0, o_overflow=0, o_state=0, o_data=0.
REQ-037 Reset asserted mid-SETTLE or with FIFO contents SHALL discard all pending data; after release, the first accepted value is pushed regardless of its value.
REQ-038 Reset deassertion is synchronized externally; the block SHALL leave IDLE no earlier than the 1st edge after release.

Verification
REQ-039 Reset release, i_en=0, i_a=8'h5A held -> o_valid=1, o_data=8'h5A, o_count=1 after the 6th edge; no second push.
REQ-040 i_a toggles 8'h11/8'h22 every 2 cycles, i_en=0 -> no push; then held at 8'h22 -> exactly one push of 8'h22.
REQ-041 i_en=1 with i_a changing freely -> o_state=0 and no push; i_en falls with i_a=8'h33 -> one push of 8'h33.
REQ-042 i_ready=0, five distinct stable values 01..05 -> o_count=4, FIFO holds 01..04, o_overflow=1; i_clr_ovf -> 0; drain order is 01,02,03,04.
REQ-043 FIFO full with i_ready=1 while a sixth value is accepted -> push and pop in one cycle, o_count=4, o_overflow stays 0.
REQ-044 i_arst_n pulsed low during SETTLE with o_count=2 -> o_count=0; resettling on an unchanged i_a pushes that value again.
